// File: rtl/ara_perf_pkg.sv
// ara_perf_pkg: shared types and defaults for the Ara performance window controller.
//   state_e      - window FSM state, values match the state_o encoding
//   DefNrEvents  - default number of event counters (dcache, icache, scoreboard)
//   DefCntWidth  - default counter / snapshot width
package ara_perf_pkg;

    localparam int unsigned DefNrEvents = 3;
    localparam int unsigned DefCntWidth = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCount  = 2'd1,
        StDrain  = 2'd2,
        StUnused = 2'd3
    } state_e;

endpackage

// File: rtl/ara_sat_counter.sv
// ara_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i - clock
//   rst_i - asynchronous active-high reset, zeroes the count
//   en    - increment by one this cycle
//   clr   - synchronous clear, takes priority over en
//   cnt   - current registered count
module ara_sat_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             clr,
    output logic [Width-1:0] cnt
);

    localparam logic [Width-1:0] One    = Width'(1);
    localparam logic [Width-1:0] MaxCnt = {Width{1'b1}};

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != MaxCnt)) begin
            r_cnt <= r_cnt + One;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ara_perf_window_ctrl.sv
// ara_perf_window_ctrl: measures Ara activity windows.
// A window opens on a dispatch while software counting is enabled, keeps counting
// while enabled, and drains until Ara goes idle once software disables counting.
// Runtime and per-event counters are saturating and accumulate across windows;
// snapshots capture them when Ara goes idle after a dispatch.
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   sw_en_i      - software counting enable (level)
//   req_valid_i  - vector instruction dispatched this cycle
//   ara_idle_i   - Ara has nothing in flight
//   clear_i      - zero counters/snapshots (honoured only in IDLE)
//   event_i      - per-event increment strobes
//   runtime_o    - runtime snapshot
//   event_cnt_o  - event snapshots
//   snap_valid_o - one-cycle pulse when snapshots update
//   state_o      - current FSM state
module ara_perf_window_ctrl
    import ara_perf_pkg::*;
#(
    parameter int unsigned NrEvents = DefNrEvents,
    parameter int unsigned CntWidth = DefCntWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               sw_en_i,
    input  logic                               req_valid_i,
    input  logic                               ara_idle_i,
    input  logic                               clear_i,
    input  logic [NrEvents-1:0]                event_i,
    output logic [CntWidth-1:0]                runtime_o,
    output logic [NrEvents-1:0][CntWidth-1:0] event_cnt_o,
    output logic                               snap_valid_o,
    output logic [1:0]                         state_o
);

    state_e                             r_state;
    state_e                             w_state_next;
    logic                               w_active;
    logic                               w_clr;
    logic                               w_snap;
    logic                               r_pending;
    logic                               r_snap_valid;
    logic [CntWidth-1:0]                r_runtime_snap;
    logic [NrEvents-1:0][CntWidth-1:0] r_event_snap;
    logic [CntWidth-1:0]                w_runtime_cnt;
    logic [NrEvents-1:0][CntWidth-1:0] w_event_cnt;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (sw_en_i && req_valid_i) begin
                    w_state_next = StCount;
                end
            end
            StCount: begin
                if (!sw_en_i) begin
                    w_state_next = ara_idle_i ? StIdle : StDrain;
                end
            end
            StDrain: begin
                if (sw_en_i) begin
                    w_state_next = StCount;
                end else if (ara_idle_i) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: decoded controls
    always_comb begin
        w_active = (r_state == StCount) || (r_state == StDrain);
        w_clr    = clear_i && (r_state == StIdle);
    end

    // A snapshot is due once Ara drains after a dispatch; a dispatch in the
    // same cycle means Ara is busy again, so the snapshot is deferred.
    assign w_snap = r_pending && ara_idle_i && !req_valid_i;

    ara_sat_counter #(
        .Width (CntWidth)
    ) u_runtime_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (w_active),
        .clr   (w_clr),
        .cnt   (w_runtime_cnt)
    );

    for (genvar k = 0; k < NrEvents; k++) begin : g_event_cnt
        ara_sat_counter #(
            .Width (CntWidth)
        ) u_event_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en    (w_active && event_i[k]),
            .clr   (w_clr),
            .cnt   (w_event_cnt[k])
        );
    end

    // Snapshot registers, pending flag and valid pulse; clear beats snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending      <= 1'b0;
            r_snap_valid   <= 1'b0;
            r_runtime_snap <= '0;
            r_event_snap   <= '0;
        end else if (w_clr) begin
            r_pending      <= 1'b0;
            r_snap_valid   <= 1'b0;
            r_runtime_snap <= '0;
            r_event_snap   <= '0;
        end else begin
            r_snap_valid <= w_snap;
            if (w_snap) begin
                r_runtime_snap <= w_runtime_cnt;
                r_event_snap   <= w_event_cnt;
            end
            if (req_valid_i) begin
                r_pending <= 1'b1;
            end else if (w_snap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign runtime_o    = r_runtime_snap;
    assign event_cnt_o  = r_event_snap;
    assign snap_valid_o = r_snap_valid;
    assign state_o      = r_state;

endmodule

// File: tb/tb_ara_perf_window_ctrl.sv
// tb_ara_perf_window_ctrl: directed bench for ara_perf_window_ctrl.
// Two instances share stimulus: default 64-bit counters and 8-bit counters
// (the latter exercises saturation). A behavioural model predicts all outputs
// and is compared every cycle; literal expectations pin the model.
module tb_ara_perf_window_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sw_en, req_valid, ara_idle, clear;
    logic [2:0] event_in;

    logic [63:0]      rt64;
    logic [2:0][63:0] ec64;
    logic             sv64;
    logic [1:0]       st64;
    logic [7:0]       rt8;
    logic [2:0][7:0]  ec8;
    logic             sv8;
    logic [1:0]       st8;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    ara_perf_window_ctrl u_dut64 (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_en_i      (sw_en),
        .req_valid_i  (req_valid),
        .ara_idle_i   (ara_idle),
        .clear_i      (clear),
        .event_i      (event_in),
        .runtime_o    (rt64),
        .event_cnt_o  (ec64),
        .snap_valid_o (sv64),
        .state_o      (st64)
    );

    ara_perf_window_ctrl #(
        .NrEvents (3),
        .CntWidth (8)
    ) u_dut8 (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_en_i      (sw_en),
        .req_valid_i  (req_valid),
        .ara_idle_i   (ara_idle),
        .clear_i      (clear),
        .event_i      (event_in),
        .runtime_o    (rt8),
        .event_cnt_o  (ec8),
        .snap_valid_o (sv8),
        .state_o      (st8)
    );

    // Behavioural model. Index 0 = 64-bit instance, 1 = 8-bit instance.
    longint unsigned m_max [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd255};
    longint unsigned m_rt [2];
    longint unsigned m_ev [2][3];
    longint unsigned m_srt [2];
    longint unsigned m_sev [2][3];
    int              m_mode = 0;   // 0 idle, 1 counting, 2 draining
    bit              m_pend = 0;
    bit              m_sv   = 0;

    initial begin
        for (int w = 0; w < 2; w++) begin
            m_rt[w]  = 0;
            m_srt[w] = 0;
            for (int k = 0; k < 3; k++) begin
                m_ev[w][k]  = 0;
                m_sev[w][k] = 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_pend = 0;
            m_sv   = 0;
            for (int w = 0; w < 2; w++) begin
                m_rt[w]  = 0;
                m_srt[w] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_ev[w][k]  = 0;
                    m_sev[w][k] = 0;
                end
            end
        end else begin
            bit in_window;
            bit wipe;
            bit take;
            in_window = (m_mode != 0);
            wipe      = clear && (m_mode == 0);
            take      = m_pend && ara_idle && !req_valid;
            for (int w = 0; w < 2; w++) begin
                if (wipe) begin
                    m_rt[w]  = 0;
                    m_srt[w] = 0;
                    for (int k = 0; k < 3; k++) begin
                        m_ev[w][k]  = 0;
                        m_sev[w][k] = 0;
                    end
                end else begin
                    if (take) begin
                        m_srt[w] = m_rt[w];
                        for (int k = 0; k < 3; k++) m_sev[w][k] = m_ev[w][k];
                    end
                    if (in_window) begin
                        if (m_rt[w] < m_max[w]) m_rt[w] = m_rt[w] + 1;
                        for (int k = 0; k < 3; k++)
                            if (event_in[k] && m_ev[w][k] < m_max[w]) m_ev[w][k] = m_ev[w][k] + 1;
                    end
                end
            end
            if (wipe) begin
                m_pend = 0;
                m_sv   = 0;
            end else begin
                m_sv   = take;
                m_pend = req_valid ? 1'b1 : (take ? 1'b0 : m_pend);
            end
            if (m_mode == 0) begin
                if (sw_en && req_valid) m_mode = 1;
            end else if (sw_en) begin
                m_mode = 1;
            end else if (ara_idle) begin
                m_mode = 0;
            end else begin
                m_mode = 2;
            end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("state64", 64'(st64), 64'(m_mode));
            chk("state8", 64'(st8), 64'(m_mode));
            chk("snap_valid64", 64'(sv64), 64'(m_sv));
            chk("snap_valid8", 64'(sv8), 64'(m_sv));
            chk("runtime64", rt64, m_srt[0]);
            chk("runtime8", 64'(rt8), m_srt[1]);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("event64[%0d]", k), ec64[k], m_sev[0][k]);
                chk($sformatf("event8[%0d]", k), 64'(ec8[k]), m_sev[1][k]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sv64) pulses++;
    end

    task automatic drive(input bit sw, input bit rv, input bit idle, input bit [2:0] ev,
                         input bit clr, input int n);
        sw_en     = sw;
        req_valid = rv;
        ara_idle  = idle;
        event_in  = ev;
        clear     = clr;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        sw_en = 0; req_valid = 0; ara_idle = 1; clear = 0; event_in = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(st64), 0);
        chk("rst_runtime", rt64, 0);
        chk("rst_snap_valid", 64'(sv64), 0);
        rst = 1'b0;
        @(negedge clk);

        // Window: dispatch at cycle 0, busy cycles 1-10, idle at 11.
        drive(1, 1, 1, 3'b010, 0, 1);   // event 1 outside window
        drive(1, 0, 0, 3'b001, 0, 4);
        drive(1, 0, 0, 3'b100, 0, 2);
        drive(1, 0, 0, 3'b000, 0, 4);
        drive(1, 0, 1, 3'b000, 0, 1);
        chk("win_snap_valid", 64'(sv64), 1);
        chk("win_runtime", rt64, 10);
        chk("win_ev0", ec64[0], 4);
        chk("win_ev1", ec64[1], 0);
        chk("win_ev2", ec64[2], 2);
        chk("win_runtime8", 64'(rt8), 10);

        // Drain: disable while busy, then idle.
        drive(0, 0, 0, 3'b000, 0, 1);
        chk("drain_state", 64'(st64), 2);
        drive(0, 0, 0, 3'b000, 0, 5);
        drive(0, 0, 1, 3'b000, 0, 1);
        chk("drain_to_idle", 64'(st64), 0);
        drive(0, 1, 1, 3'b000, 0, 1);   // dispatch with idle: snapshot deferred
        chk("defer_snap", 64'(sv64), 0);
        drive(0, 0, 1, 3'b000, 0, 1);
        chk("drain_snap_valid", 64'(sv64), 1);
        chk("drain_runtime", rt64, 18);
        #1 chk("pulse_count", 64'(pulses), 2);

        // Clear ignored while counting, honoured in IDLE.
        drive(1, 1, 0, 3'b000, 0, 1);
        drive(1, 0, 0, 3'b000, 1, 1);
        drive(0, 0, 1, 3'b000, 0, 1);
        chk("clr_ignored_runtime", rt64, 19);
        chk("clr_ignored_state", 64'(st64), 0);
        drive(0, 1, 1, 3'b000, 0, 1);
        drive(0, 0, 1, 3'b000, 1, 1);   // clear coincides with snapshot
        chk("clr_runtime", rt64, 0);
        chk("clr_ev0", ec64[0], 0);
        chk("clr_snap_valid", 64'(sv64), 0);
        drive(0, 0, 1, 3'b000, 0, 2);
        #1 chk("clr_no_pulse", 64'(pulses), 3);

        // Saturation: 300-cycle window.
        drive(1, 1, 0, 3'b000, 0, 1);
        drive(1, 0, 0, 3'b000, 0, 300);
        drive(1, 0, 1, 3'b000, 0, 1);
        chk("sat_runtime8", 64'(rt8), 255);
        chk("sat_runtime64", rt64, 300);

        // Reset mid-window.
        drive(0, 0, 1, 3'b000, 0, 1);
        drive(1, 1, 0, 3'b000, 0, 1);
        drive(1, 0, 0, 3'b000, 0, 50);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 64'(st64), 0);
        chk("arst_runtime", rt64, 0);
        chk("arst_runtime8", 64'(rt8), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int p0;
            #1 p0 = pulses;
            drive(1, 0, 1, 3'b000, 0, 5);
            #1 chk("post_rst_no_pulse", 64'(pulses), 64'(p0));
            chk("post_rst_state", 64'(st64), 0);
        end
        drive(1, 1, 1, 3'b000, 0, 1);
        drive(1, 0, 1, 3'b000, 0, 1);
        chk("post_rst_snap", 64'(sv64), 1);
        drive(0, 0, 1, 3'b000, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ara_perf_window_ctrl.md
ARA_PERF_WINDOW_CTRL -- requirements
Module: ara_perf_window_ctrl

Interface
REQ-001 SHALL have parameter NrEvents, default 3, number of event counters (dcache stall, icache stall, scoreboard full).
REQ-002 SHALL have parameter CntWidth, default 64, width of every counter and snapshot register.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw_en_i  input  1  software counting enable (level).
REQ-006 SHALL have port req_valid_i  input  1  vector instruction dispatched to Ara this cycle.
REQ-007 SHALL have port ara_idle_i  input  1  Ara has no instruction in flight.
REQ-008 SHALL have port clear_i  input  1  single-cycle pulse that zeroes counters and snapshots.
REQ-009 SHALL have port event_i  input  NrEvents  per-event increment strobes.
REQ-010 SHALL have port runtime_o  output  CntWidth  runtime snapshot.
REQ-011 SHALL have port event_cnt_o  output  NrEvents x CntWidth  event snapshots.
REQ-012 SHALL have port snap_valid_o  output  1  one-cycle pulse when the snapshots update.
REQ-013 SHALL have port state_o  output  2  current FSM state (IDLE=0, COUNT=1, DRAIN=2).

Function
REQ-014 SHALL implement FSM states IDLE, COUNT and DRAIN; encoding 3 is unreachable and SHALL return to IDLE.
REQ-015 IDLE SHALL go to COUNT when sw_en_i & req_valid_i; the runtime counter SHALL first increment in the cycle after the transition.
REQ-016 COUNT SHALL stay in COUNT while sw_en_i=1; when sw_en_i=0 it SHALL go to IDLE if ara_idle_i=1, otherwise to DRAIN.
REQ-017 DRAIN SHALL go to COUNT when sw_en_i=1, to IDLE when sw_en_i=0 & ara_idle_i=1, and otherwise stay in DRAIN.
REQ-018 In COUNT and DRAIN, the runtime counter SHALL increment by 1 every cycle.
REQ-019 In COUNT and DRAIN, event counter k SHALL increment by 1 in each cycle where event_i[k]=1.
REQ-020 All counters SHALL saturate at 2^CntWidth-1 and SHALL hold that value; they SHALL never wrap.
REQ-021 Counters SHALL hold their value in IDLE and SHALL accumulate across successive windows.
REQ-022 A pending flag SHALL be set in any state on req_valid_i=1.
REQ-023 When pending=1 & ara_idle_i=1 & req_valid_i=0, the block SHALL copy the registered counter values of that cycle into the snapshots, clear pending and assert snap_valid_o in the next cycle for exactly one cycle.
REQ-024 req_valid_i=1 together with ara_idle_i=1 SHALL keep pending set and SHALL NOT update the snapshots.
REQ-025 clear_i SHALL zero all counters, all snapshots and pending when accepted in IDLE; in COUNT or DRAIN it SHALL be ignored.
REQ-026 If clear_i and a snapshot condition coincide in IDLE, clear_i SHALL win: the snapshots read 0 and snap_valid_o stays 0.
REQ-027 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-028 rst_i=1 SHALL immediately force state IDLE, all counters and snapshots 0, pending 0, snap_valid_o 0 and state_o 0.
REQ-029 Reset asserted in mid-window SHALL discard the window; no snapshot SHALL be produced after release until a new req_valid_i arrives.

Structure
REQ-030 Package ara_perf_pkg SHALL hold the state enum type, the default CntWidth and the default NrEvents.
REQ-031 A single sub-module, ara_sat_counter (parameter Width; inputs en, clr; output cnt), SHALL be instantiated NrEvents+1 times.
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 sw_en=1, req_valid pulse at cycle 0, ara_idle low for cycles 1-10 then high -> snap_valid pulses once; runtime_o=10.
REQ-034 event_i[0] high 4 cycles and event_i[2] high 2 cycles inside the window -> event_cnt_o = {2,0,4}; counts outside the window are ignored.
REQ-035 sw_en drops while ara_idle=0 -> state DRAIN; counting continues until ara_idle=1, then state IDLE.
REQ-036 With CntWidth=8 and a window of 300 cycles -> runtime_o=255.
REQ-037 clear_i in COUNT -> no effect; clear_i in IDLE -> all outputs 0 next cycle.
REQ-038 Reset asserted mid-COUNT with runtime=50 -> all outputs 0 asynchronously; no snap_valid after release until a new req_valid.
